// File: rtl/uart_pkg.sv
// Shared types and defaults for the debug-link UART receiver.
package uart_pkg;

   localparam int unsigned DefaultN          = 8;
   localparam int unsigned DefaultCountTicks = 16;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } rx_state_e;

   function automatic logic [3:0] state_to_leds(rx_state_e s);
      return 4'b0001 << s;
   endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side signal bundle: line and tick in, byte and status out.
interface uart_receiver_if #(
   parameter int unsigned N = uart_pkg::DefaultN
);
   logic         tick;
   logic         rx;
   logic [N-1:0] data_out;
   logic         valid;
   logic         frame_err;
   logic [3:0]   state_leds;
   logic         started;

   modport master (
      output tick, rx,
      input  data_out, valid, frame_err, state_leds, started
   );

   modport slave (
      input  tick, rx,
      output data_out, valid, frame_err, state_leds, started
   );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
   parameter logic ResetVal = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= ResetVal;
         sync_q <= ResetVal;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule

// File: rtl/uart_receiver.sv
// Oversampling 8N1 receiver: start-bit qualification at mid bit, LSB-first shift, stop check.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned N           = DefaultN,
   parameter int unsigned COUNT_TICKS = DefaultCountTicks
) (
   input logic            clk,
   input logic            reset,
   uart_receiver_if.slave bus
);
   localparam int unsigned TW = $clog2(COUNT_TICKS);
   localparam int unsigned BW = $clog2(N);

   localparam logic [TW-1:0] TickHalf = TW'(COUNT_TICKS / 2 - 1);
   localparam logic [TW-1:0] TickLast = TW'(COUNT_TICKS - 1);
   localparam logic [BW-1:0] BitLast  = BW'(N - 1);

   rx_state_e    state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [N-1:0]  shift_q, shift_d;
   logic [N-1:0]  data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          rx_s;

   sync_2ff #(
      .ResetVal(1'b1)
   ) u_rx_sync (
      .clk  (clk),
      .reset(reset),
      .d_i  (bus.rx),
      .q_o  (rx_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Start edge is checked every clk; a coincident tick is deliberately not counted.
            if (!rx_s) begin
               tick_cnt_d = '0;
               state_d    = StStart;
            end
         end
         StStart: begin
            if (bus.tick) begin
               if (tick_cnt_q == TickHalf) begin
                  if (!rx_s) begin
                     tick_cnt_d = '0;
                     bit_cnt_d  = '0;
                     state_d    = StData;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         StData: begin
            if (bus.tick) begin
               if (tick_cnt_q == TickLast) begin
                  shift_d    = {rx_s, shift_q[N-1:1]};
                  tick_cnt_d = '0;
                  if (bit_cnt_q == BitLast) begin
                     state_d = StStop;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         StStop: begin
            if (bus.tick) begin
               if (tick_cnt_q == TickLast) begin
                  // Leaving mid stop bit lets an immediately following start edge be caught.
                  if (rx_s) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
                  state_d = StIdle;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.data_out   = data_q;
   assign bus.valid      = valid_q;
   assign bus.frame_err  = ferr_q;
   assign bus.state_leds = state_to_leds(state_q);
   assign bus.started    = (state_q != StIdle);
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: tick every 4 clks, 16 ticks per bit (64 clks per bit).
module tb_uart_receiver;
   localparam int BitClks = 64;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   int         valid_cnt;
   int         ferr_cnt;
   int         both_cnt;
   logic [7:0] valid_data[$];
   logic [3:0] leds_trace[$];
   logic [3:0] prev_leds;
   logic [1:0] tick_div;

   uart_receiver_if #(.N(8)) bus ();

   uart_receiver #(
      .N          (8),
      .COUNT_TICKS(16)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      tick_div = 2'd0;
      bus.tick = 1'b0;
      forever begin
         @(negedge clk);
         tick_div = tick_div + 2'd1;
         bus.tick = (tick_div == 2'd3);
      end
   end

   initial begin
      valid_cnt = 0;
      ferr_cnt  = 0;
      both_cnt  = 0;
      prev_leds = 4'b0001;
      forever begin
         @(negedge clk);
         if (bus.valid === 1'b1) begin
            valid_cnt++;
            valid_data.push_back(bus.data_out);
         end
         if (bus.frame_err === 1'b1) ferr_cnt++;
         if (bus.valid === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
         if (bus.state_leds !== prev_leds) begin
            leds_trace.push_back(bus.state_leds);
            prev_leds = bus.state_leds;
         end
      end
   end

   task automatic clear_trace();
      @(posedge clk);
      #1;
      leds_trace.delete();
      valid_data.delete();
      prev_leds = bus.state_leds;
      @(negedge clk);
   endtask

   task automatic drive_bit(input logic v, input int len);
      bus.rx = v;
      repeat (len) @(negedge clk);
   endtask

   task automatic idle(input int len);
      drive_bit(1'b1, len);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
      drive_bit(1'b0, BitClks);
      for (int i = 0; i < 8; i++) drive_bit(b[i], BitClks);
      drive_bit(stop, stop_len);
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      bus.rx = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.state_leds !== 4'b0001) begin
         errors++;
         $display("FAIL reset_leds got %b exp 0001", bus.state_leds);
      end
      checks++;
      if (bus.started !== 1'b0 || bus.valid !== 1'b0 || bus.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got started=%b valid=%b ferr=%b exp 0 0 0",
                  bus.started, bus.valid, bus.frame_err);
      end
      checks++;
      if (bus.data_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_data got %h exp 00", bus.data_out);
      end
      reset = 1'b0;
      idle(20);
   endtask

   task automatic test_frame_07();
      int v0;
      clear_trace();
      v0 = valid_cnt;
      send_frame(8'h07, 1'b1, BitClks);
      idle(20);
      checks++;
      if (valid_cnt - v0 != 1) begin
         errors++;
         $display("FAIL f07_valid_clks got %0d exp 1", valid_cnt - v0);
      end
      checks++;
      if (bus.data_out !== 8'h07) begin
         errors++;
         $display("FAIL f07_data got %h exp 07", bus.data_out);
      end
      checks++;
      if (bus.started !== 1'b0) begin
         errors++;
         $display("FAIL f07_started got %b exp 0", bus.started);
      end
      checks++;
      if (leds_trace.size() != 4 || leds_trace[0] !== 4'b0010 || leds_trace[1] !== 4'b0100 ||
          leds_trace[2] !== 4'b1000 || leds_trace[3] !== 4'b0001) begin
         errors++;
         $display("FAIL f07_leds_seq got %p exp 0010 0100 1000 0001", leds_trace);
      end
   endtask

   task automatic test_back_to_back();
      int v0;
      int f0;
      clear_trace();
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(8'hA5, 1'b1, BitClks);
      send_frame(8'h3C, 1'b1, BitClks);
      idle(20);
      checks++;
      if (valid_cnt - v0 != 2) begin
         errors++;
         $display("FAIL b2b_valid_count got %0d exp 2", valid_cnt - v0);
      end
      checks++;
      if (valid_data.size() < 1 || valid_data[0] !== 8'hA5) begin
         errors++;
         $display("FAIL b2b_first got %p exp a5", valid_data);
      end
      checks++;
      if (valid_data.size() < 2 || valid_data[1] !== 8'h3C) begin
         errors++;
         $display("FAIL b2b_second got %p exp 3c", valid_data);
      end
      checks++;
      if (ferr_cnt != f0) begin
         errors++;
         $display("FAIL b2b_ferr got %0d exp 0", ferr_cnt - f0);
      end
   endtask

   task automatic test_glitch();
      int v0;
      int f0;
      clear_trace();
      v0 = valid_cnt;
      f0 = ferr_cnt;
      drive_bit(1'b0, 12);
      idle(100);
      checks++;
      if (leds_trace.size() != 2 || leds_trace[0] !== 4'b0010 || leds_trace[1] !== 4'b0001) begin
         errors++;
         $display("FAIL glitch_leds_seq got %p exp 0010 0001", leds_trace);
      end
      checks++;
      if (valid_cnt != v0 || ferr_cnt != f0) begin
         errors++;
         $display("FAIL glitch_pulses got valid=%0d ferr=%0d exp 0 0", valid_cnt - v0, ferr_cnt - f0);
      end
      checks++;
      if (bus.data_out !== 8'h3C) begin
         errors++;
         $display("FAIL glitch_data got %h exp 3c", bus.data_out);
      end
   endtask

   task automatic test_frame_error();
      int v0;
      int f0;
      send_frame(8'h12, 1'b1, BitClks);
      idle(40);
      checks++;
      if (bus.data_out !== 8'h12) begin
         errors++;
         $display("FAIL ferr_prior_data got %h exp 12", bus.data_out);
      end
      v0 = valid_cnt;
      f0 = ferr_cnt;
      // Stop bit held low only long enough to cover its mid-bit sample point.
      send_frame(8'h55, 1'b0, 40);
      idle(150);
      checks++;
      if (ferr_cnt - f0 != 1) begin
         errors++;
         $display("FAIL ferr_pulse_clks got %0d exp 1", ferr_cnt - f0);
      end
      checks++;
      if (valid_cnt != v0) begin
         errors++;
         $display("FAIL ferr_valid got %0d exp 0", valid_cnt - v0);
      end
      checks++;
      if (bus.data_out !== 8'h12) begin
         errors++;
         $display("FAIL ferr_data got %h exp 12", bus.data_out);
      end
   endtask

   task automatic test_boundaries();
      logic [7:0] pats[2];
      int v0;
      pats[0] = 8'h00;
      pats[1] = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         v0 = valid_cnt;
         send_frame(pats[i], 1'b1, BitClks);
         idle(30);
         checks++;
         if (valid_cnt - v0 != 1 || bus.data_out !== pats[i]) begin
            errors++;
            $display("FAIL boundary_%0d got data=%h valid=%0d exp data=%h valid=1",
                     i, bus.data_out, valid_cnt - v0, pats[i]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      int v0;
      int f0;
      b  = 8'hC3;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      drive_bit(1'b0, BitClks);
      for (int i = 0; i < 4; i++) drive_bit(b[i], BitClks);
      drive_bit(b[4], BitClks / 2);
      checks++;
      if (bus.state_leds !== 4'b0100) begin
         errors++;
         $display("FAIL midrst_in_data got %b exp 0100", bus.state_leds);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.state_leds !== 4'b0001 || bus.started !== 1'b0 || bus.data_out !== 8'h00 ||
          bus.valid !== 1'b0 || bus.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL midrst_outputs got leds=%b st=%b data=%h v=%b fe=%b exp 0001 0 00 0 0",
                  bus.state_leds, bus.started, bus.data_out, bus.valid, bus.frame_err);
      end
      reset = 1'b0;
      idle(100);
      checks++;
      if (valid_cnt != v0 || ferr_cnt != f0) begin
         errors++;
         $display("FAIL midrst_aborted got valid=%0d ferr=%0d exp 0 0", valid_cnt - v0, ferr_cnt - f0);
      end
      send_frame(8'h81, 1'b1, BitClks);
      idle(30);
      checks++;
      if (valid_cnt - v0 != 1 || bus.data_out !== 8'h81) begin
         errors++;
         $display("FAIL midrst_next got data=%h valid=%0d exp 81 1", bus.data_out, valid_cnt - v0);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus.rx = 1'b1;
      @(negedge clk);
      test_reset();
      test_frame_07();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_boundaries();
      test_reset_mid_frame();
      checks++;
      if (both_cnt != 0) begin
         errors++;
         $display("FAIL valid_and_ferr got %0d exp 0", both_cnt);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
